stopwatch_ctrl: RTL and testbench
=================================

# stopwatch_ctrl

Button-driven controller that sequences a free-running stopwatch counter (start/stop/reset command pulses, count input) for the timer subsystem. It turns two raw push-button levels into a three-state run/hold/idle FSM and emits single-cycle commands to the counter. It captures lap times into a small FIFO that downstream logic drains over a valid/ready handshake, and it counts counter wrap-arounds.

## Interface
- DATA_WIDTH, 16: width of the counter value and lap entries
- MAX, 99: terminal count of the sequenced counter (wraps MAX→0)
- LAP_DEPTH, 4: lap FIFO entries, power of two, ≥2
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- btn_ss  in  1  start/stop button level
- btn_lr  in  1  lap/reset button level
- count  in  DATA_WIDTH  current counter value
- sw_start  out  1  one-cycle start command to counter
- sw_stop  out  1  one-cycle stop command to counter
- sw_reset  out  1  one-cycle reset command to counter
- state  out  2  FSM state: IDLE=0, RUN=1, HOLD=2
- lap_valid  out  1  lap FIFO non-empty
- lap_data  out  DATA_WIDTH  head lap entry
- lap_ready  in  1  consumer pop; pop occurs when lap_valid && lap_ready
- lap_overflow  out  1  sticky: a lap was dropped because the FIFO was full
- wraps  out  8  saturating count of MAX→0 wraps while in RUN

## Operation
- Press = rising edge: button sampled 1 at edge k and 0 at edge k-1. The previous-level registers reset to 0, so a button held through reset registers a press at the first edge after reset.
- IDLE: ss press → RUN, sw_start. lr press → no effect.
- RUN: ss press → HOLD, sw_stop. lr press → push count (value sampled at edge k) into lap FIFO; stay in RUN.
- HOLD: ss press → RUN, sw_start. lr press → IDLE, sw_reset, flush FIFO, clear lap_overflow and wraps.
- Simultaneous presses in RUN: lap captured and sw_stop issued; → HOLD.
- Simultaneous presses in HOLD: reset wins; → IDLE, sw_reset only, no sw_start.
- Simultaneous presses in IDLE: → RUN, sw_start.
- At most one of sw_start/sw_stop/sw_reset is high in any cycle.
- Lap push when FIFO full: entry dropped, contents unchanged, lap_overflow set.
- Push and pop in the same cycle when full: pop frees the slot and the push succeeds.
- Flush and pop in the same cycle: flush wins, FIFO empty.
- wraps increments when state==RUN, previous-cycle count==MAX and count==0. Saturates at 255.
- Reset values: state IDLE, all sw_* 0, lap_valid 0, lap_data 0, lap_overflow 0, wraps 0, FIFO empty, button history 0.

## Timing
- Press detected at edge k → state and sw_* are registered at edge k, high for exactly the cycle following edge k.
- Lap entry is written at edge k. lap_valid rises after edge k if the FIFO was empty (one-cycle capture-to-valid latency).
- lap_data is the registered/array head, stable while lap_valid && !lap_ready.
- Pop at edge j → next entry (or lap_valid=0) visible after edge j.
- Flush, overflow clear and wraps clear all take effect at the same edge as the sw_reset assertion.
- No combinational path from btn_* or count to any output.

## Structure
- stopwatch_pkg: state enum (IDLE/RUN/HOLD), 2-bit state width constant, WRAP_WIDTH=8.
- Sub-module lap_fifo (parameters DATA_WIDTH, LAP_DEPTH): synchronous FIFO with push/pop/flush, full/empty, pointer-plus-one-bit occupancy.
- stopwatch_ctrl holds the edge detectors, FSM, command registers, overflow flag and wrap counter.

## Test plan
- Reset with btn_ss held high → after reset release, one press detected: state=RUN, sw_start high one cycle; nothing else asserted.
- ss, wait, ss, ss → states RUN, HOLD, RUN with sw_start, sw_stop, sw_start pulses one cycle each. lr in IDLE → no pulse, state stays IDLE.
- In RUN, lr presses at count=5,17,42 with lap_ready=0 → lap_valid 1; pop three times → lap_data 5,17,42, then lap_valid 0.
- LAP_DEPTH=4, five lr presses without pops → four entries retained, fifth dropped, lap_overflow=1. Push and pop on the same edge while full → push accepted.
- HOLD with both buttons rising on the same edge → sw_reset only, state IDLE, FIFO empty, lap_overflow=0, wraps=0.
- Drive count 98,99,0 in RUN → wraps=1. Same sequence in HOLD → wraps unchanged. 300 wraps → wraps=255.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state encoding and widths for the stopwatch controller
package stopwatch_pkg;
  localparam int STATE_WIDTH = 2;
  localparam int WRAP_WIDTH = 8;
  typedef enum logic [STATE_WIDTH-1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2} state_t;
endpackage

// File: rtl/stopwatch_ctrl_lap_fifo.sv
// lap_fifo: synchronous lap FIFO with flush; a pop frees a slot for a same-cycle push
module lap_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int LAP_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  empty,
  output logic                  drop
);
  localparam int AW = $clog2(LAP_DEPTH);
  logic [DATA_WIDTH-1:0] mem [LAP_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic full, do_push, do_pop;
  always_comb begin
    empty = wr_ptr == rd_ptr;
    full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    do_pop = pop && !empty;
    do_push = push && (!full || do_pop);
    drop = push && !do_push && !flush;
    dout = empty ? '0 : mem[rd_ptr[AW-1:0]];
  end
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= din;
endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: button edge detect, run/hold/idle FSM, counter commands, lap capture and wrap count
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int MAX = 99,
  parameter int LAP_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   btn_ss,
  input  logic                   btn_lr,
  input  logic [DATA_WIDTH-1:0]  count,
  output logic                   sw_start,
  output logic                   sw_stop,
  output logic                   sw_reset,
  output logic [STATE_WIDTH-1:0] state,
  output logic                   lap_valid,
  output logic [DATA_WIDTH-1:0]  lap_data,
  input  logic                   lap_ready,
  output logic                   lap_overflow,
  output logic [WRAP_WIDTH-1:0]  wraps
);
  state_t st, nxt;
  logic ss_q, lr_q, ss_p, lr_p;
  logic start_d, stop_d, reset_d, lap_push, empty, drop;
  logic [DATA_WIDTH-1:0] prev_count;
  assign ss_p = btn_ss && !ss_q;
  assign lr_p = btn_lr && !lr_q;
  assign state = st;
  assign lap_valid = !empty;
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= IDLE;
      ss_q <= 1'b0;
      lr_q <= 1'b0;
      sw_start <= 1'b0;
      sw_stop <= 1'b0;
      sw_reset <= 1'b0;
    end else begin
      st <= nxt;
      ss_q <= btn_ss;
      lr_q <= btn_lr;
      sw_start <= start_d;
      sw_stop <= stop_d;
      sw_reset <= reset_d;
    end
  end
  // In HOLD a lap/reset press takes priority over start/stop
  always_comb begin
    nxt = st;
    case (st)
      IDLE: nxt = ss_p ? RUN : IDLE;
      RUN:  nxt = ss_p ? HOLD : RUN;
      HOLD: nxt = lr_p ? IDLE : ss_p ? RUN : HOLD;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    start_d = ss_p && (st == IDLE || (st == HOLD && !lr_p));
    stop_d = ss_p && st == RUN;
    reset_d = lr_p && st == HOLD;
    lap_push = lr_p && st == RUN;
  end
  lap_fifo #(.DATA_WIDTH(DATA_WIDTH), .LAP_DEPTH(LAP_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(lap_push),
    .pop(lap_ready),
    .flush(reset_d),
    .din(count),
    .dout(lap_data),
    .empty(empty),
    .drop(drop)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      lap_overflow <= 1'b0;
      wraps <= '0;
      prev_count <= '0;
    end else begin
      prev_count <= count;
      if (reset_d) lap_overflow <= 1'b0;
      else if (drop) lap_overflow <= 1'b1;
      if (reset_d) wraps <= '0;
      else if (st == RUN && prev_count == DATA_WIDTH'(MAX) && count == '0 && wraps != '1)
        wraps <= wraps + 1'b1;
    end
  end
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed checks of commands, lap FIFO, overflow and wrap counting
module tb_stopwatch_ctrl;
  logic clk = 1'b0, reset = 1'b1, btn_ss = 1'b0, btn_lr = 1'b0, lap_ready = 1'b0;
  logic [15:0] count = '0;
  logic sw_start, sw_stop, sw_reset, lap_valid, lap_overflow;
  logic [1:0] state;
  logic [15:0] lap_data;
  logic [7:0] wraps;
  int checks = 0, errors = 0;

  stopwatch_ctrl #(.DATA_WIDTH(16), .MAX(99), .LAP_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .btn_ss(btn_ss), .btn_lr(btn_lr), .count(count),
    .sw_start(sw_start), .sw_stop(sw_stop), .sw_reset(sw_reset), .state(state),
    .lap_valid(lap_valid), .lap_data(lap_data), .lap_ready(lap_ready),
    .lap_overflow(lap_overflow), .wraps(wraps)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic ss, input logic lr);
    btn_ss = ss;
    btn_lr = lr;
    tick();
  endtask

  task automatic release_btns;
    btn_ss = 1'b0;
    btn_lr = 1'b0;
    tick();
  endtask

  task automatic cmds(input string tag, input int st, input int s, input int p, input int r);
    check({tag, " state"}, state, st);
    check({tag, " sw_start"}, sw_start, s);
    check({tag, " sw_stop"}, sw_stop, p);
    check({tag, " sw_reset"}, sw_reset, r);
  endtask

  initial begin
    btn_ss = 1'b1;
    tick();
    tick();
    cmds("reset", 0, 0, 0, 0);
    check("reset lap_valid", lap_valid, 0);
    check("reset lap_data", lap_data, 0);
    check("reset overflow", lap_overflow, 0);
    check("reset wraps", wraps, 0);
    reset = 1'b0;
    tick();
    cmds("held ss", 1, 1, 0, 0);
    check("held ss lap_valid", lap_valid, 0);
    tick();
    cmds("held ss 2", 1, 0, 0, 0);
    btn_ss = 1'b0;
    tick();

    press(1, 0); cmds("run->hold", 2, 0, 1, 0);
    release_btns(); cmds("hold rel", 2, 0, 0, 0);
    press(1, 0); cmds("hold->run", 1, 1, 0, 0);
    release_btns(); cmds("run rel", 1, 0, 0, 0);
    press(1, 0); cmds("run->hold 2", 2, 0, 1, 0);
    release_btns();
    press(0, 1); cmds("hold->idle", 0, 0, 0, 1);
    release_btns(); cmds("idle rel", 0, 0, 0, 0);
    press(0, 1); cmds("idle lr", 0, 0, 0, 0);
    release_btns();
    press(1, 1); cmds("idle both", 1, 1, 0, 0);
    check("idle both lap_valid", lap_valid, 0);
    release_btns();

    count = 16'd5; press(0, 1);
    check("lap1 valid", lap_valid, 1);
    check("lap1 data", lap_data, 5);
    cmds("lap1", 1, 0, 0, 0);
    release_btns();
    count = 16'd17; press(0, 1); release_btns();
    count = 16'd42; press(0, 1); release_btns();
    check("laps head held", lap_data, 5);
    lap_ready = 1'b1;
    tick(); check("pop1 data", lap_data, 17);
    tick(); check("pop2 data", lap_data, 42);
    tick(); check("pop3 valid", lap_valid, 0);
    check("pop3 data", lap_data, 0);
    lap_ready = 1'b0;

    for (int i = 1; i <= 5; i++) begin
      count = 16'(i);
      press(0, 1);
      check($sformatf("fill%0d overflow", i), lap_overflow, i == 5);
      release_btns();
    end
    check("full head", lap_data, 1);
    count = 16'd77; lap_ready = 1'b1; press(0, 1);
    lap_ready = 1'b0;
    release_btns();
    check("push+pop head", lap_data, 2);
    check("overflow sticky", lap_overflow, 1);
    lap_ready = 1'b1;
    tick(); check("drain 3", lap_data, 3);
    tick(); check("drain 4", lap_data, 4);
    tick(); check("drain 77", lap_data, 77);
    tick(); check("drain empty", lap_valid, 0);
    lap_ready = 1'b0;

    count = 16'd98; tick();
    count = 16'd99; tick();
    count = 16'd0; tick();
    check("wrap run", wraps, 1);
    count = 16'd33; press(1, 1);
    cmds("run both", 2, 0, 1, 0);
    check("run both lap_valid", lap_valid, 1);
    check("run both lap_data", lap_data, 33);
    release_btns();
    count = 16'd98; tick();
    count = 16'd99; tick();
    count = 16'd0; tick();
    check("wrap hold", wraps, 1);
    lap_ready = 1'b1; press(1, 1);
    lap_ready = 1'b0;
    cmds("hold both", 0, 0, 0, 1);
    check("hold both lap_valid", lap_valid, 0);
    check("hold both overflow", lap_overflow, 0);
    check("hold both wraps", wraps, 0);
    release_btns();
    check("sw_reset one cycle", sw_reset, 0);

    press(1, 0); release_btns();
    for (int i = 0; i < 300; i++) begin
      count = 16'd99; tick();
      count = 16'd0; tick();
    end
    check("wrap saturate", wraps, 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
